// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 19-bit instructions,
// writes them to consecutive IMEM addresses and holds the CPU until done.
`default_nettype none

module imem_loader #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  loaded_count
);

  localparam int HI_W  = INSTR_W - 16;
  localparam int CHI_W = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_B0   = 3'd3,
    S_B1   = 3'd4,
    S_B2   = 3'd5,
    S_WR   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               im_we_q;
  logic [ADDR_W-1:0]  im_addr_q;
  logic [INSTR_W-1:0] im_wdata_q;
  logic               cpu_hold_q;
  logic               busy_q;
  logic               done_q;
  logic [ADDR_W-1:0]  loaded_count_q;
  logic [ADDR_W-1:0]  count_q;
  logic [CHI_W-1:0]   cnt_hi_q;
  logic [HI_W-1:0]    b0_q;
  logic [7:0]         b1_q;

  logic               hs;
  logic [ADDR_W-1:0]  lc_inc;

  assign hs     = in_valid && in_ready_q;
  assign lc_inc = loaded_count_q + ONE;

  // Every output is a register loaded alongside the state that decodes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      im_we_q        <= 1'b0;
      im_addr_q      <= '0;
      im_wdata_q     <= '0;
      cpu_hold_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      loaded_count_q <= '0;
      count_q        <= '0;
      cnt_hi_q       <= '0;
      b0_q           <= '0;
      b1_q           <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q        <= S_HDR0;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b1;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            loaded_count_q <= '0;
            im_addr_q      <= '0;
          end
        end
        S_HDR0: begin
          if (hs) begin
            cnt_hi_q <= in_data[CHI_W-1:0];
            state_q  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (hs) begin
            count_q <= {cnt_hi_q, in_data};
            if ({cnt_hi_q, in_data} == '0) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              cpu_hold_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_B0;
            end
          end
        end
        S_B0: begin
          if (hs) begin
            b0_q    <= in_data[HI_W-1:0];
            state_q <= S_B1;
          end
        end
        S_B1: begin
          if (hs) begin
            b1_q    <= in_data;
            state_q <= S_B2;
          end
        end
        S_B2: begin
          if (hs) begin
            im_wdata_q <= {b0_q, b1_q, in_data};
            im_we_q    <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= S_WR;
          end
        end
        S_WR: begin
          im_we_q        <= 1'b0;
          loaded_count_q <= lc_inc;
          if (lc_inc == count_q) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            state_q    <= S_B0;
            in_ready_q <= 1'b1;
            im_addr_q  <= im_addr_q + ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign loaded_count = loaded_count_q;

endmodule

`default_nettype wire
